stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/timer_pkg.sv | 23 ++
 rtl/key_debounce.sv | 66 ++++++
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_t        : FSM state encoding (IDLE/RUN/PAUSE/OVER)
//   DEF_CLK_FREQ   : default clock cycles per count tick (1 s at 50 MHz)
//   DEF_DEB_CYCLES : default key debounce length (20 ms at 50 MHz)
//   KEY_*          : bit positions of the keys in the debounced press vector
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_DEB_CYCLES = 1_000_000;

    localparam int NUM_KEYS = 3;
    localparam int KEY_SP   = 0;
    localparam int KEY_CLR  = 1;
    localparam int KEY_RST  = 2;

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-FF synchronizer, debouncer and press detector.
//   clk   : system clock
//   reset : synchronous, active-low
//   key_n : raw key level, asynchronous, low = pressed
//   press : one-cycle pulse per accepted high-to-low transition
module key_debounce
    import timer_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic [DW-1:0] cnt_reg;
    logic [1:0]    prime_reg;
    logic          armed_reg;
    logic          press_reg;

    // prime_reg marks when sync2_reg holds a real sample rather than the
    // value loaded by reset. A press is only reported once the key has been
    // seen released after reset, so a key held through reset stays silent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            prime_reg <= '0;
            armed_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            prime_reg <= {prime_reg[0], 1'b1};
            press_reg <= 1'b0;
            if (prime_reg[1] && sync2_reg && level_reg) begin
                armed_reg <= 1'b1;
            end
            // Count consecutive samples that disagree with the accepted
            // level; any agreeing sample restarts the count.
            if (sync2_reg != level_reg) begin
                if (cnt_reg == DEB_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    press_reg <= level_reg & armed_reg;
                end else begin
                    cnt_reg <= cnt_reg + DW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced keys, 1-tick prescaler and run/pause/overflow FSM.
//   clk       : system clock
//   reset     : synchronous, active-low
//   en        : global enable, low freezes prescaler, state and flags
//   key_sp_n  : raw start/pause key (active-low)
//   key_clr_n : raw clear key (active-low)
//   key_rst_n : raw reset key (active-low)
//   cnt_max   : external counter is at its maximum
//   cnt_inc   : one-cycle increment pulse to the counter
//   cnt_clr   : one-cycle clear pulse to the counter
//   run_flag  : high while in RUN
//   over_flag : overflow LED, toggles each tick in OVER
//   state     : current FSM state
module stopwatch_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       key_sp_n,
    input  logic       key_clr_n,
    input  logic       key_rst_n,
    input  logic       cnt_max,
    output logic       cnt_inc,
    output logic       cnt_clr,
    output logic       run_flag,
    output logic       over_flag,
    output logic [1:0] state
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    logic [NUM_KEYS-1:0] key_n_vec;
    logic [NUM_KEYS-1:0] press;

    assign key_n_vec[KEY_SP]  = key_sp_n;
    assign key_n_vec[KEY_CLR] = key_clr_n;
    assign key_n_vec[KEY_RST] = key_rst_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_key (
                .clk   (clk),
                .reset (reset),
                .key_n (key_n_vec[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    state_t        state_reg;
    state_t        state_next;
    logic          over_reg;
    logic          over_next;
    logic          run_reg;
    logic [PW-1:0] presc_reg;
    logic          counting;
    logic          tick;
    logic          rst_ev;
    logic          clr_ev;
    logic          sp_ev;
    logic          tick_ev;

    assign counting = (state_reg == ST_RUN) || (state_reg == ST_OVER);
    assign tick     = counting && (presc_reg == PRESC_LAST);

    // One event per cycle: the highest-priority one wins, the rest are dropped.
    assign rst_ev  = en & press[KEY_RST];
    assign clr_ev  = en & press[KEY_CLR] & ~press[KEY_RST];
    assign sp_ev   = en & press[KEY_SP] & ~press[KEY_CLR] & ~press[KEY_RST];
    assign tick_ev = en & tick & ~(|press);

    // Prescaler only advances in RUN/OVER; held at zero otherwise so the
    // first tick after entering RUN takes a full CLK_FREQ cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_reg <= '0;
        end else if (en) begin
            if (!counting) begin
                presc_reg <= '0;
            end else if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            over_reg  <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            over_reg  <= over_next;
            run_reg   <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state_reg;
        over_next  = over_reg;
        if (rst_ev) begin
            state_next = ST_IDLE;
            over_next  = 1'b0;
        end else if (clr_ev) begin
            // counter clear only; state and flags untouched
            state_next = state_reg;
        end else if (sp_ev) begin
            case (state_reg)
                ST_IDLE, ST_PAUSE: state_next = ST_RUN;
                ST_RUN:            state_next = ST_PAUSE;
                default:           state_next = state_reg;
            endcase
        end else if (tick_ev) begin
            case (state_reg)
                ST_RUN: begin
                    if (cnt_max) begin
                        state_next = ST_OVER;
                        over_next  = 1'b1;
                    end
                end
                ST_OVER: over_next = ~over_reg;
                default: over_next = over_reg;
            endcase
        end
    end

    always_comb begin
        cnt_inc = (state_reg == ST_RUN) && tick_ev && !cnt_max;
        cnt_clr = rst_ev || clr_ev || ((state_reg == ST_RUN) && tick_ev && cnt_max);
    end

    assign run_flag  = run_reg;
    assign over_flag = over_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       key_sp_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic       key_rst_n = 1'b1;
    logic       cnt_max = 1'b0;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       run_flag;
    logic       over_flag;
    logic [1:0] state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_FREQ   (10),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .key_sp_n  (key_sp_n),
        .key_clr_n (key_clr_n),
        .key_rst_n (key_rst_n),
        .cnt_max   (cnt_max),
        .cnt_inc   (cnt_inc),
        .cnt_clr   (cnt_clr),
        .run_flag  (run_flag),
        .over_flag (over_flag),
        .state     (state)
    );

    int total = 0;
    int bad = 0;

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int inc_total = 0;
    int clr_total = 0;
    int overlap_cnt = 0;
    int run_entry_cyc = -1;
    int first_inc_cyc = -1;
    int second_inc_cyc = -1;
    logic [1:0] prev_state = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_state <= state;
        if (cnt_inc === 1'b1) begin
            inc_total <= inc_total + 1;
            if (first_inc_cyc < 0) first_inc_cyc <= cyc;
            else if (second_inc_cyc < 0) second_inc_cyc <= cyc;
        end
        if (cnt_clr === 1'b1) clr_total <= clr_total + 1;
        if (cnt_inc === 1'b1 && cnt_clr === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if (state == 2'b01 && prev_state != 2'b01 && run_entry_cyc < 0) run_entry_cyc <= cyc;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // rb/sp/cl/rk are raw pin levels (0 = asserted), n = cycles to hold,
    // then the state/flags after the window and pulses counted inside it.
    typedef struct {
        int rb, en, sp, cl, rk, cm, n;
        int st, run, ov, inc, clr;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t mk(int rb, int e, int sp, int cl, int rk, int cm, int n,
                                int st, int run, int ov, int inc, int clr);
        vec_t v;
        v.rb = rb; v.en = e; v.sp = sp; v.cl = cl; v.rk = rk; v.cm = cm; v.n = n;
        v.st = st; v.run = run; v.ov = ov; v.inc = inc; v.clr = clr;
        return v;
    endfunction

    initial begin
        //          rb en sp cl rk cm  n    st run ov inc clr
        vt[0]  = mk(0, 1, 1, 1, 1, 0,  3,   0, 0, 0, 0, 0);  // reset state
        vt[1]  = mk(1, 1, 0, 1, 1, 0,  3,   0, 0, 0, 0, 0);  // 3-cycle glitch
        vt[2]  = mk(1, 1, 1, 1, 1, 0, 10,   0, 0, 0, 0, 0);
        vt[3]  = mk(1, 1, 0, 1, 1, 0, 20,   1, 1, 0, 1, 0);  // held press -> RUN
        vt[4]  = mk(1, 1, 1, 1, 1, 0, 10,   1, 1, 0, 1, 0);
        vt[5]  = mk(1, 0, 0, 1, 1, 0, 12,   1, 1, 0, 0, 0);  // en=0 across press/tick
        vt[6]  = mk(1, 1, 0, 1, 1, 0,  7,   1, 1, 0, 1, 0);  // resumes from held value
        vt[7]  = mk(1, 1, 1, 1, 1, 0, 10,   1, 1, 0, 1, 0);
        vt[8]  = mk(1, 1, 1, 1, 1, 1, 10,   3, 0, 1, 0, 1);  // overflow
        vt[9]  = mk(1, 1, 1, 1, 1, 1, 10,   3, 0, 0, 0, 0);  // blink
        vt[10] = mk(1, 1, 0, 1, 1, 0, 10,   3, 0, 1, 0, 0);  // sp ignored in OVER
        vt[11] = mk(0, 1, 0, 0, 0, 0,  1,   0, 0, 0, 0, 0);  // 1-cycle reset, keys low
        vt[12] = mk(1, 1, 0, 0, 0, 0, 12,   0, 0, 0, 0, 0);  // held keys stay silent
        vt[13] = mk(1, 1, 1, 1, 1, 0, 10,   0, 0, 0, 0, 0);
        vt[14] = mk(1, 1, 0, 1, 1, 0, 10,   1, 1, 0, 0, 0);
        vt[15] = mk(1, 1, 1, 1, 1, 0,  8,   1, 1, 0, 1, 0);
        vt[16] = mk(1, 1, 1, 0, 0, 0, 10,   0, 0, 0, 0, 1);  // rst+clr together
        vt[17] = mk(1, 1, 1, 1, 1, 0,  8,   0, 0, 0, 0, 0);
        vt[18] = mk(1, 1, 0, 1, 1, 1, 17,   3, 0, 1, 0, 1);  // IDLE->RUN->OVER
        vt[19] = mk(1, 1, 1, 0, 1, 0, 10,   3, 0, 0, 0, 1);  // clr keeps OVER
        vt[20] = mk(1, 1, 1, 1, 1, 0, 10,   3, 0, 1, 0, 0);
        vt[21] = mk(1, 1, 1, 1, 0, 0,  7,   0, 0, 0, 0, 1);  // rst clears over_flag
        vt[22] = mk(1, 1, 1, 1, 1, 0,  8,   0, 0, 0, 0, 0);
        vt[23] = mk(1, 1, 0, 1, 1, 0,  8,   1, 1, 0, 0, 0);
        vt[24] = mk(1, 1, 1, 1, 1, 0,  8,   1, 1, 0, 0, 0);
        vt[25] = mk(1, 1, 0, 1, 1, 0,  8,   2, 0, 0, 1, 0);  // RUN->PAUSE
        vt[26] = mk(1, 1, 1, 1, 1, 0, 20,   2, 0, 0, 0, 0);  // PAUSE holds
        vt[27] = mk(1, 1, 0, 1, 1, 0, 16,   1, 1, 0, 0, 0);  // PAUSE->RUN
        vt[28] = mk(1, 1, 1, 1, 1, 0,  1,   1, 1, 0, 1, 0);  // tick exactly 10 later

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            int inc0, clr0;
            reset     = (vt[i].rb != 0);
            en        = (vt[i].en != 0);
            key_sp_n  = (vt[i].sp != 0);
            key_clr_n = (vt[i].cl != 0);
            key_rst_n = (vt[i].rk != 0);
            cnt_max   = (vt[i].cm != 0);
            inc0 = inc_total;
            clr0 = clr_total;
            repeat (vt[i].n) @(posedge clk);
            #1;
            $display("vec %0d: state=%0d run=%0d over=%0d inc=%0d clr=%0d",
                     i, state, run_flag, over_flag, inc_total - inc0, clr_total - clr0);
            chk($sformatf("v%0d.state", i), int'(state), vt[i].st);
            chk($sformatf("v%0d.run_flag", i), int'(run_flag), vt[i].run);
            chk($sformatf("v%0d.over_flag", i), int'(over_flag), vt[i].ov);
            chk($sformatf("v%0d.cnt_inc", i), inc_total - inc0, vt[i].inc);
            chk($sformatf("v%0d.cnt_clr", i), clr_total - clr0, vt[i].clr);
        end

        // RUN is first visible in the cycle after the entry edge; the first
        // increment is consumed CLK_FREQ=10 edges after that entry edge.
        $display("timing: entry=%0d inc1=%0d inc2=%0d", run_entry_cyc, first_inc_cyc, second_inc_cyc);
        chk("first_inc_delay", first_inc_cyc - run_entry_cyc, 9);
        chk("inc_period", second_inc_cyc - first_inc_cyc, 10);
        chk("inc_clr_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
